// File: rtl/load_pkg.sv
// -----------------------------------------------------------------------------
// load_pkg
// Shared definitions for the MEM-stage load/store lane logic: FSM state
// encoding for the load aligner, access-size encoding (also used by the store
// byte-enable block) and load error codes.
// -----------------------------------------------------------------------------
package load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    // Access size encoding, shared with the store byte-enable path.
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Load completion status.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // True when the access cannot be served from a single aligned word,
    // or when the size code is the reserved one.
    function automatic logic is_misaligned(input logic [1:0] word,
                                           input logic [1:0] low_addr);
        case (word)
            SZ_WORD: return (low_addr != 2'b00);
            SZ_HALF: return low_addr[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational lane selector: picks the addressed byte/halfword/word out of a
// little-endian read word and sign- or zero-extends it to 32 bits.
// Ports:
//   mem_data  in  32  raw read word (lane0 = [7:0])
//   low_addr  in  2   address bits [1:0]
//   word      in  2   access size (SZ_WORD/SZ_HALF/SZ_BYTE)
//   zero_ext  in  1   1 = zero-extend, 0 = sign-extend (ignored for words)
//   ext_data  out 32  extended result
// -----------------------------------------------------------------------------
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] mem_data,
    input  logic [1:0]  low_addr,
    input  logic [1:0]  word,
    input  logic        zero_ext,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every signal written in a combinational block gets a value on
        // every path (defaults first), otherwise synthesis infers a latch.
        byte_lane = mem_data[7:0];
        case (low_addr)
            2'b01:   byte_lane = mem_data[15:8];
            2'b10:   byte_lane = mem_data[23:16];
            2'b11:   byte_lane = mem_data[31:24];
            default: byte_lane = mem_data[7:0];
        endcase

        half_lane = low_addr[1] ? mem_data[31:16] : mem_data[15:0];

        ext_data = mem_data;
        case (word)
            SZ_BYTE: ext_data = zero_ext ? {24'b0, byte_lane}
                                         : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: ext_data = zero_ext ? {16'b0, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
            default: ext_data = mem_data;
        endcase
    end

endmodule

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// MEM-stage load aligner. Accepts a load request, strobes the data memory,
// waits (bounded) for read data, extracts and extends the addressed lane and
// holds the result for WB under a valid/ready handshake.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   ReqValid   in   1   load request present
//   ReqReady   out  1   request accepted when ReqValid & ReqReady
//   LowAddr    in   2   address bits [1:0]
//   Word       in   2   size code (00 word, 01 half, 10 byte, 11 illegal)
//   Unsigned   in   1   1 = zero-extend, 0 = sign-extend
//   MemRd      out  1   one-cycle read strobe
//   MemValid   in   1   read data valid
//   MemData    in   32  read word
//   LoadValid  out  1   result valid, held until LoadReady
//   LoadReady  in   1   WB consumes result
//   LoadData   out  32  extended load result
//   ErrCode    out  2   00 ok, 01 misaligned/illegal, 10 timeout
// -----------------------------------------------------------------------------
module load_align
    import load_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  LowAddr,
    input  logic [1:0]  Word,
    input  logic        Unsigned,
    output logic        MemRd,
    input  logic        MemValid,
    input  logic [31:0] MemData,
    output logic        LoadValid,
    input  logic        LoadReady,
    output logic [31:0] LoadData,
    output logic [1:0]  ErrCode
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       addr_q, addr_d;
    logic [1:0]       word_q, word_d;
    logic             uns_q, uns_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       err_q, err_d;
    logic             mem_rd_q, mem_rd_d;

    logic [31:0]      extracted;
    logic             accept;
    logic             wait_last;

    // Extraction works on the latched request; MemData is only sampled in WAIT.
    load_extract u_extract (
        .mem_data (MemData),
        .low_addr (addr_q),
        .word     (word_q),
        .zero_ext (uns_q),
        .ext_data (extracted)
    );

    // A request can be taken while the previous result is being retired,
    // giving back-to-back loads without an IDLE bubble.
    assign ReqReady  = !rst && (state_q == IDLE || (state_q == DONE && LoadReady));
    assign accept    = ReqValid && ReqReady;
    assign wait_last = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        word_d   = word_q;
        uns_d    = uns_q;
        data_d   = data_q;
        err_d    = err_q;
        mem_rd_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && LoadReady && !accept) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    addr_d = LowAddr;
                    word_d = Word;
                    uns_d  = Unsigned;
                    if (is_misaligned(Word, LowAddr)) begin
                        // Rejected without touching memory.
                        state_d = DONE;
                        err_d   = ERR_ALIGN;
                        data_d  = '0;
                    end else begin
                        state_d  = WAIT;
                        cnt_d    = '0;
                        mem_rd_d = 1'b1;
                    end
                end
            end

            WAIT: begin
                // Data arriving on the last permitted cycle still wins.
                if (MemValid) begin
                    state_d = DONE;
                    data_d  = extracted;
                    err_d   = ERR_NONE;
                end else if (wait_last) begin
                    state_d = DONE;
                    data_d  = '0;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            word_q   <= SZ_WORD;
            uns_q    <= 1'b0;
            data_q   <= '0;
            err_q    <= ERR_NONE;
            mem_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            uns_q    <= uns_d;
            data_q   <= data_d;
            err_q    <= err_d;
            mem_rd_q <= mem_rd_d;
        end
    end

    assign MemRd     = mem_rd_q;
    assign LoadValid = (state_q == DONE);
    assign LoadData  = data_q;
    assign ErrCode   = err_q;

endmodule
